// File: rtl/spike_pkg.sv
// Shared types and widths for the spike generator: pulse and window FSM
// state encodings plus the spike-count width.
package spike_pkg;

  localparam int SPIKE_CNT_W = 32;

  typedef enum logic [1:0] {P_LOW, P_HIGH, P_GAP} pulse_state_t;
  typedef enum logic       {W_IDLE, W_RUN}        win_state_t;

endpackage

// File: rtl/spike_pulse_shaper.sv
// Turns single-cycle due strobes into fixed-width spikes with an equal low gap,
// queueing excess strobes in a saturating pending counter.
module spike_pulse_shaper
  import spike_pkg::*;
#(
  parameter int PULSE_CYCLES = 200,
  parameter int PEND_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_due,
  input  logic                   i_win_tick,
  output logic                   o_spike,
  output logic [PEND_W-1:0]      o_pending,
  output logic                   o_overflow,
  output logic [SPIKE_CNT_W-1:0] o_emit_cnt,
  output pulse_state_t           o_state
);

  localparam int PC_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PC_W-1:0]   PC_LAST  = PC_W'(PULSE_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  pulse_state_t           r_state;
  logic [PC_W-1:0]        r_hold_cnt;
  logic [PEND_W-1:0]      r_pending;
  logic                   r_overflow;
  logic                   r_spike;
  logic [SPIKE_CNT_W-1:0] r_win_emit;
  logic [SPIKE_CNT_W-1:0] r_emit_cnt;

  logic w_work;
  logic w_hold_done;
  logic w_start;

  assign w_work      = (r_pending != '0) | i_due;
  assign w_hold_done = (r_hold_cnt == PC_LAST);
  // The last GAP cycle may launch the next spike directly, giving a 2*PULSE_CYCLES period.
  assign w_start     = w_work & ((r_state == P_LOW) | ((r_state == P_GAP) & w_hold_done));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= P_LOW;
      r_hold_cnt <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_spike    <= 1'b0;
      r_win_emit <= '0;
      r_emit_cnt <= '0;
    end else begin
      case (r_state)
        P_LOW: begin
          if (w_start) begin
            r_state    <= P_HIGH;
            r_spike    <= 1'b1;
            r_hold_cnt <= '0;
          end
        end
        P_HIGH: begin
          if (w_hold_done) begin
            r_state    <= P_GAP;
            r_spike    <= 1'b0;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        P_GAP: begin
          if (w_hold_done) begin
            r_hold_cnt <= '0;
            if (w_start) begin
              r_state <= P_HIGH;
              r_spike <= 1'b1;
            end else begin
              r_state <= P_LOW;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= P_LOW;
          r_spike <= 1'b0;
        end
      endcase

      if (i_due && !w_start) begin
        if (r_pending == PEND_MAX) r_overflow <= 1'b1;
        else                       r_pending  <= r_pending + 1'b1;
      end else if (!i_due && w_start) begin
        r_pending <= r_pending - 1'b1;
      end

      // A spike launched on the tick cycle belongs to the window that tick opens.
      if (i_win_tick) begin
        r_emit_cnt <= r_win_emit;
        r_win_emit <= {{(SPIKE_CNT_W-1){1'b0}}, w_start};
      end else if (w_start) begin
        r_win_emit <= r_win_emit + 1'b1;
      end
    end
  end

  assign o_spike    = r_spike;
  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;
  assign o_emit_cnt = r_emit_cnt;
  assign o_state    = r_state;

endmodule

// File: rtl/spike_generator.sv
// Rate-to-spike-train converter: a DDA spreads cnt_in spikes across each slow_clk window.
// Optional SPIKE_GEN_WINDOW_MEAS_EN measures the tick interval and uses it as the window length.
module spike_generator
  import spike_pkg::*;
#(
  parameter int PULSE_CYCLES   = 200,
  parameter int DEFAULT_WINDOW = 200000,
  parameter int PEND_W         = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   slow_clk,
  input  logic [SPIKE_CNT_W-1:0] cnt_in,
  output logic                   spike,
  output logic [SPIKE_CNT_W-1:0] emit_cnt,
  output logic [PEND_W-1:0]      pending,
  output logic                   overflow,
  output logic [SPIKE_CNT_W-1:0] window_len,
  output win_state_t             dbg_win_state,
  output pulse_state_t           dbg_pulse_state
);

  localparam logic [SPIKE_CNT_W-1:0] DEF_WL = SPIKE_CNT_W'(DEFAULT_WINDOW);

  logic                   r_sync_meta;
  logic                   r_sync;
  logic                   r_sync_d;
  win_state_t             r_win_state;
  logic [SPIKE_CNT_W-1:0] r_rate;
  logic [SPIKE_CNT_W-1:0] r_acc;

  logic                   w_win_tick;
  logic                   w_due;
  logic [SPIKE_CNT_W:0]   w_acc_next;
  logic [SPIKE_CNT_W:0]   w_acc_wrap;
  logic [SPIKE_CNT_W-1:0] w_window_len;

  assign w_win_tick = r_sync & ~r_sync_d;
  assign w_acc_next = {1'b0, r_acc} + {1'b0, r_rate};
  assign w_acc_wrap = w_acc_next - {1'b0, w_window_len};
  // A tick in the same cycle suppresses due; the accumulator restarts instead.
  assign w_due      = (r_win_state == W_RUN) & ~w_win_tick &
                      (w_acc_next >= {1'b0, w_window_len});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
      r_sync_d    <= 1'b0;
      r_win_state <= W_IDLE;
      r_rate      <= '0;
      r_acc       <= '0;
    end else begin
      r_sync_meta <= slow_clk;
      r_sync      <= r_sync_meta;
      r_sync_d    <= r_sync;
      if (w_win_tick) begin
        r_win_state <= W_RUN;
        r_rate      <= (cnt_in < w_window_len) ? cnt_in : w_window_len;
        r_acc       <= '0;
      end else if (r_win_state == W_RUN) begin
        r_acc <= w_due ? w_acc_wrap[SPIKE_CNT_W-1:0] : w_acc_next[SPIKE_CNT_W-1:0];
      end
    end
  end

`ifdef SPIKE_GEN_WINDOW_MEAS_EN
  logic [SPIKE_CNT_W-1:0] r_meas_cnt;
  logic [SPIKE_CNT_W-1:0] r_window_len;

  // r_meas_cnt holds the cycles elapsed since the previous tick, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meas_cnt   <= '0;
      r_window_len <= DEF_WL;
    end else if (w_win_tick) begin
      r_meas_cnt <= SPIKE_CNT_W'(1);
      if ((r_win_state == W_RUN) && (r_meas_cnt != '0)) r_window_len <= r_meas_cnt;
    end else if (r_meas_cnt != '1) begin
      r_meas_cnt <= r_meas_cnt + 1'b1;
    end
  end

  assign w_window_len = r_window_len;
`else
  assign w_window_len = DEF_WL;
`endif

  spike_pulse_shaper #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .PEND_W      (PEND_W)
  ) u_shaper (
    .clk       (clk),
    .reset     (reset),
    .i_due     (w_due),
    .i_win_tick(w_win_tick),
    .o_spike   (spike),
    .o_pending (pending),
    .o_overflow(overflow),
    .o_emit_cnt(emit_cnt),
    .o_state   (dbg_pulse_state)
  );

  assign window_len    = w_window_len;
  assign dbg_win_state = r_win_state;

endmodule

// File: tb/tb_spike_generator.sv
// Bench for spike_generator (PULSE_CYCLES=2, DEFAULT_WINDOW=100) against a
// cycle-stepped reference built from window arithmetic and pulse-spacing rules.
module tb_spike_generator;
  import spike_pkg::*;

  localparam int P    = 2;
  localparam int DW   = 100;
  localparam int PW   = 8;
  localparam int SC_N = 32768;

  logic         clk = 1'b0;
  logic         reset;
  logic         slow_clk;
  logic [31:0]  cnt_in;
  logic         spike;
  logic [31:0]  emit_cnt;
  logic [PW-1:0] pending;
  logic         overflow;
  logic [31:0]  window_len;
  win_state_t   dbg_win_state;
  pulse_state_t dbg_pulse_state;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          cyc = 0;
  bit          sc [0:SC_N-1];
  bit          m_run;
  int          m_tick;
  longint      m_rate;
  longint      m_wl;
  bit          m_has_start;
  int          m_last_start;
  int          m_pending;
  bit          m_ovf;
  int          m_win_starts;
  int          m_emit;
  logic [31:0] exp_q [$];

  spike_generator #(
    .PULSE_CYCLES  (P),
    .DEFAULT_WINDOW(DW),
    .PEND_W        (PW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .slow_clk       (slow_clk),
    .cnt_in         (cnt_in),
    .spike          (spike),
    .emit_cnt       (emit_cnt),
    .pending        (pending),
    .overflow       (overflow),
    .window_len     (window_len),
    .dbg_win_state  (dbg_win_state),
    .dbg_pulse_state(dbg_pulse_state)
  );

  always #5 clk = ~clk;

  function automatic bit exp_spike();
    return m_has_start && (cyc - m_last_start >= 1) && (cyc - m_last_start <= P);
  endfunction

  // Advance the model by the current cycle's inputs, then clock the DUT.
  task automatic step();
    int     k;
    bit     tick, due, start;
    longint n, new_wl;
    k = cyc;
    sc[k] = slow_clk;
    if (reset) begin
      m_run = 0; m_tick = 0; m_rate = 0; m_wl = DW;
      m_has_start = 0; m_last_start = 0; m_pending = 0; m_ovf = 0;
      m_win_starts = 0; m_emit = 0;
    end else begin
      tick = (k >= 3) && sc[k-2] && !sc[k-3];
      due = 0;
      if (tick) begin
        new_wl = m_wl;
`ifdef SPIKE_GEN_WINDOW_MEAS_EN
        if (m_run && (k != m_tick)) new_wl = k - m_tick;
`endif
        m_rate = (longint'(cnt_in) < m_wl) ? longint'(cnt_in) : m_wl;
        m_wl = new_wl;
        m_tick = k;
        m_run = 1;
      end else if (m_run) begin
        n = k - m_tick;
        due = ((n * m_rate) / m_wl) != (((n - 1) * m_rate) / m_wl);
      end
      start = ((m_pending > 0) || due) && (!m_has_start || (k - m_last_start >= 2 * P));
      if (tick) begin
        exp_q.push_back(32'(m_win_starts));
        m_emit = m_win_starts;
        m_win_starts = 0;
      end
      if (start) begin
        m_win_starts++;
        m_has_start = 1;
        m_last_start = k;
      end
      if (due && !start && m_pending == (1 << PW) - 1) m_ovf = 1;
      else m_pending = m_pending + int'(due) - int'(start);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; slow_clk = 1'b0; cnt_in = '0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (spike !== 1'b0) begin n_bad++; $display("FAIL reset_spike cyc=%0d got=%0b exp=0", cyc, spike); end
    end
    n_cmp++;
    if (window_len !== 32'd100) begin n_bad++; $display("FAIL reset_window_len got=%0d exp=100", window_len); end
    n_cmp++;
    if (pending !== 8'd0 || overflow !== 1'b0 || emit_cnt !== 32'd0) begin
      n_bad++; $display("FAIL reset_counters got pend=%0d ovf=%0b emit=%0d exp=0/0/0", pending, overflow, emit_cnt);
    end
  endtask

  task automatic test_rate10();
    int rises = 0;
    int last = -1;
    bit prev;
    cnt_in = 32'd10;
    for (int i = 0; i < 110; i++) begin
      slow_clk = (i < 4) || (i >= 101 && i < 105);
      prev = spike;
      step();
      n_cmp++;
      if (spike !== exp_spike() || pending !== 8'(m_pending)) begin
        n_bad++; $display("FAIL rate10_cycle cyc=%0d got spike=%0b pend=%0d exp spike=%0b pend=%0d", cyc, spike, pending, exp_spike(), m_pending);
      end
      if (spike && !prev) begin
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last != 10) begin n_bad++; $display("FAIL rate10_spacing got=%0d exp=10", cyc - last); end
        end
        last = cyc;
        rises++;
      end
    end
    n_cmp++;
    if (rises != 10) begin n_bad++; $display("FAIL rate10_count got=%0d exp=10", rises); end
    n_cmp++;
    if (emit_cnt !== 32'd10) begin n_bad++; $display("FAIL rate10_emit_cnt got=%0d exp=10", emit_cnt); end
  endtask

  task automatic test_saturation();
    int last = -1;
    int gap = 0;
    bit prev;
    cnt_in = 32'd40;
    for (int i = 0; i < 2200; i++) begin
      slow_clk = (i % 100) < 4;
      prev = spike;
      step();
      n_cmp++;
      if (spike !== exp_spike() || pending !== 8'(m_pending) || overflow !== m_ovf) begin
        n_bad++; $display("FAIL sat_cycle cyc=%0d got spike=%0b pend=%0d ovf=%0b exp spike=%0b pend=%0d ovf=%0b", cyc, spike, pending, overflow, exp_spike(), m_pending, m_ovf);
      end
      if (spike && !prev) begin
        if (last >= 0) gap = cyc - last;
        last = cyc;
      end
    end
    n_cmp++;
    if (gap != 2 * P) begin n_bad++; $display("FAIL sat_period got=%0d exp=%0d", gap, 2 * P); end
    n_cmp++;
    if (pending !== 8'd255 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL sat_final got pend=%0d ovf=%0b exp pend=255 ovf=1", pending, overflow);
    end
    n_cmp++;
    if (emit_cnt !== 32'(m_emit)) begin n_bad++; $display("FAIL sat_emit_cnt got=%0d exp=%0d", emit_cnt, m_emit); end
  endtask

  task automatic test_drain();
    cnt_in = 32'd0;
    for (int i = 0; i < 1200; i++) begin
      slow_clk = (i < 4);
      step();
      n_cmp++;
      if (spike !== exp_spike() || pending !== 8'(m_pending)) begin
        n_bad++; $display("FAIL drain_cycle cyc=%0d got spike=%0b pend=%0d exp spike=%0b pend=%0d", cyc, spike, pending, exp_spike(), m_pending);
      end
    end
    n_cmp++;
    if (pending !== 8'd0 || spike !== 1'b0 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL drain_final got pend=%0d spike=%0b ovf=%0b exp 0/0/1", pending, spike, overflow);
    end
  endtask

  task automatic test_reset_mid_pulse();
    bit hit = 0;
    cnt_in = 32'd100;
    for (int i = 0; i < 100 && !hit; i++) begin
      slow_clk = (i < 4);
      step();
      n_cmp++;
      if (spike !== exp_spike() || pending !== 8'(m_pending)) begin
        n_bad++; $display("FAIL midrst_cycle cyc=%0d got spike=%0b pend=%0d exp spike=%0b pend=%0d", cyc, spike, pending, exp_spike(), m_pending);
      end
      if (i >= 8 && exp_spike() && m_pending > 2) hit = 1;
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL midrst_setup got=no_pulse exp=pulse_with_pending"); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (spike !== 1'b0 || pending !== 8'd0 || overflow !== 1'b0 || emit_cnt !== 32'd0 || window_len !== 32'd100) begin
      n_bad++; $display("FAIL midrst_after got spike=%0b pend=%0d ovf=%0b emit=%0d wl=%0d exp 0/0/0/0/100", spike, pending, overflow, emit_cnt, window_len);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (spike !== 1'b0) begin n_bad++; $display("FAIL midrst_quiet cyc=%0d got=%0b exp=0", cyc, spike); end
    end
  endtask

  task automatic test_random();
    int gap;
    logic [31:0] exp;
    exp_q.delete();
    for (int w = 0; w < 8; w++) begin
      gap = $urandom_range(40, 160);
      cnt_in = $urandom_range(0, 130);
      for (int i = 0; i < gap; i++) begin
        slow_clk = (i < 4);
        if (i == gap / 2) cnt_in = $urandom;
        step();
        n_cmp++;
        if (spike !== exp_spike() || pending !== 8'(m_pending) || overflow !== m_ovf) begin
          n_bad++; $display("FAIL rand_cycle cyc=%0d got spike=%0b pend=%0d ovf=%0b exp spike=%0b pend=%0d ovf=%0b", cyc, spike, pending, overflow, exp_spike(), m_pending, m_ovf);
        end
        if (m_run && m_tick == cyc - 1 && exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          n_cmp++;
          if (emit_cnt !== exp) begin n_bad++; $display("FAIL rand_emit_cnt cyc=%0d got=%0d exp=%0d", cyc, emit_cnt, exp); end
        end
      end
    end
  endtask

`ifdef SPIKE_GEN_WINDOW_MEAS_EN
  task automatic test_window_meas();
    cnt_in = 32'd20;
    for (int i = 0; i < 1000; i++) begin
      slow_clk = (i % 200) < 4;
      step();
      n_cmp++;
      if (window_len !== 32'(m_wl) || spike !== exp_spike() || pending !== 8'(m_pending)) begin
        n_bad++; $display("FAIL meas_cycle cyc=%0d got wl=%0d spike=%0b pend=%0d exp wl=%0d spike=%0b pend=%0d", cyc, window_len, spike, pending, m_wl, exp_spike(), m_pending);
      end
    end
    n_cmp++;
    if (window_len !== 32'd200) begin n_bad++; $display("FAIL meas_window_len got=%0d exp=200", window_len); end
    n_cmp++;
    if (emit_cnt !== 32'(m_emit)) begin n_bad++; $display("FAIL meas_emit_cnt got=%0d exp=%0d", emit_cnt, m_emit); end
  endtask
`endif

  initial begin
    test_reset();
    test_rate10();
    test_saturation();
    test_drain();
    test_reset_mid_pulse();
    test_random();
`ifdef SPIKE_GEN_WINDOW_MEAS_EN
    test_window_meas();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
